rf_access_ctrl: RTL and testbench

//   Initiator side of the 4x8 register-file port: drives the write enables (ce0..ce3),
//   the read select (addr) and write data, and samples the read data.

---
 rtl/rf_pkg.sv | 36 +++
 rtl/rf_ce_decode.sv | 18 +
 rtl/rf_access_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rf_access_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file access controller.
package rf_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned ADDR_W = 2;
   localparam int unsigned REG_N  = 1 << ADDR_W;
   localparam int unsigned SW_REG = 3;

   typedef enum logic [1:0] {
      OP_READ      = 2'b00,
      OP_WRITE_IMM = 2'b01,
      OP_MOVE      = 2'b10,
      OP_LOAD_SW   = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RD   = 2'b01,
      ST_WR   = 2'b10,
      ST_RESP = 2'b11
   } state_e;

   // Request payload as presented by the core sequencer
   typedef struct packed {
      op_e               op;
      logic [ADDR_W-1:0] dst;
      logic [ADDR_W-1:0] src;
      logic [DATA_W-1:0] imm;
   } req_t;

   // The switch-loaded register may not be written from the datapath
   function automatic logic dst_is_illegal(input op_e op, input logic [ADDR_W-1:0] dst);
      return ((op == OP_WRITE_IMM) || (op == OP_MOVE)) && (dst == ADDR_W'(SW_REG));
   endfunction

endpackage

// File: rtl/rf_ce_decode.sv
// Register index to one-hot write-enable decoder, gated by an enable.
module rf_ce_decode
   import rf_pkg::*;
(
   input  logic              en,
   input  logic [ADDR_W-1:0] idx,
   output logic [REG_N-1:0]  onehot_c
);

   // At most one enable bit set, none when disabled
   always_comb begin
      onehot_c = '0;
      if (en) begin
         onehot_c[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/rf_access_ctrl.sv
// Initiator side of the 4x8 register-file port: serialises READ / WRITE_IMM /
// MOVE / LOAD_SW requests and returns a one-cycle response.
module rf_access_ctrl
   import rf_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_dst,
   input  logic [ADDR_W-1:0] req_src,
   input  logic [DATA_W-1:0] req_imm,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_data,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data_out,
   output logic [DATA_W-1:0] rf_data_in,
   output logic              rf_ce0,
   output logic              rf_ce1,
   output logic              rf_ce2,
   output logic              rf_ce3
);

   req_t              req_in_c;
   state_e            state_q;
   state_e            state_d;
   op_e               op_q;
   logic [ADDR_W-1:0] dst_q;
   logic [DATA_W-1:0] imm_q;
   logic [DATA_W-1:0] data_q;

   logic              accept_c;
   logic              illegal_c;
   logic              ce_en_c;
   logic [ADDR_W-1:0] ce_idx_c;
   logic [REG_N-1:0]  ce_onehot_c;
   logic [REG_N-1:0]  ce_q;
   logic              rsp_err_d;
   logic [DATA_W-1:0] rsp_data_d;

   assign req_in_c  = '{op: op_e'(req_op), dst: req_dst, src: req_src, imm: req_imm};
   assign accept_c  = req_valid && (state_q == ST_IDLE);
   assign illegal_c = dst_is_illegal(req_in_c.op, req_in_c.dst);

   // Next state, next write enable and next response contents
   always_comb begin
      state_d    = state_q;
      ce_en_c    = 1'b0;
      ce_idx_c   = dst_q;
      rsp_err_d  = 1'b0;
      rsp_data_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (illegal_c) begin
                  state_d   = ST_RESP;
                  rsp_err_d = 1'b1;
               end else begin
                  case (req_in_c.op)
                     OP_READ,
                     OP_MOVE: state_d = ST_RD;
                     OP_WRITE_IMM: begin
                        state_d  = ST_WR;
                        ce_en_c  = 1'b1;
                        ce_idx_c = req_in_c.dst;
                     end
                     OP_LOAD_SW: begin
                        state_d  = ST_WR;
                        ce_en_c  = 1'b1;
                        ce_idx_c = ADDR_W'(SW_REG);
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end
         end
         ST_RD: begin
            if (op_q == OP_MOVE) begin
               state_d  = ST_WR;
               ce_en_c  = 1'b1;
               ce_idx_c = dst_q;
            end else begin
               state_d    = ST_RESP;
               rsp_data_d = rf_data_out;
            end
         end
         ST_WR: begin
            state_d = ST_RESP;
            case (op_q)
               OP_WRITE_IMM: rsp_data_d = imm_q;
               OP_MOVE:      rsp_data_d = data_q;
               default:      rsp_data_d = '0;
            endcase
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   rf_ce_decode u_ce_decode (
      .en       (ce_en_c),
      .idx      (ce_idx_c),
      .onehot_c (ce_onehot_c)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Request latches, loaded only on acceptance
   always_ff @(posedge clk) begin
      if (rst) begin
         op_q  <= OP_READ;
         dst_q <= '0;
         imm_q <= '0;
      end else if (accept_c) begin
         op_q  <= req_in_c.op;
         dst_q <= req_in_c.dst;
         imm_q <= req_in_c.imm;
      end
   end

   // rf-facing datapath: read select, write data and read capture
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_addr    <= '0;
         rf_data_in <= '0;
         data_q     <= '0;
      end else begin
         if (accept_c && !illegal_c) begin
            if ((req_in_c.op == OP_READ) || (req_in_c.op == OP_MOVE)) begin
               rf_addr <= req_in_c.src;
            end
            if (req_in_c.op == OP_WRITE_IMM) begin
               rf_data_in <= req_in_c.imm;
            end
         end
         if (state_q == ST_RD) begin
            data_q <= rf_data_out;
            if (op_q == OP_MOVE) begin
               rf_data_in <= rf_data_out;
            end
         end
      end
   end

   // Handshake, response and write-enable output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
         ce_q      <= '0;
      end else begin
         req_ready <= (state_d == ST_IDLE);
         rsp_valid <= (state_d == ST_RESP);
         rsp_err   <= rsp_err_d;
         rsp_data  <= rsp_data_d;
         ce_q      <= ce_onehot_c;
      end
   end

   assign rf_ce0 = ce_q[0];
   assign rf_ce1 = ce_q[1];
   assign rf_ce2 = ce_q[2];
   assign rf_ce3 = ce_q[3];

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl with a behavioural 4x8 register file.
module tb_rf_access_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [1:0] req_op;
   logic [1:0] req_dst;
   logic [1:0] req_src;
   logic [7:0] req_imm;
   logic       rsp_valid;
   logic       rsp_err;
   logic [7:0] rsp_data;
   logic [1:0] rf_addr;
   logic [7:0] rf_data_out;
   logic [7:0] rf_data_in;
   logic       rf_ce0, rf_ce1, rf_ce2, rf_ce3;

   rf_access_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_dst     (req_dst),
      .req_src     (req_src),
      .req_imm     (req_imm),
      .rsp_valid   (rsp_valid),
      .rsp_err     (rsp_err),
      .rsp_data    (rsp_data),
      .rf_addr     (rf_addr),
      .rf_data_out (rf_data_out),
      .rf_data_in  (rf_data_in),
      .rf_ce0      (rf_ce0),
      .rf_ce1      (rf_ce1),
      .rf_ce2      (rf_ce2),
      .rf_ce3      (rf_ce3)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Register file: register 3 loads the switches when its enable fires
   logic [7:0] sw = 8'h3C;
   logic [7:0] regs [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   always @(posedge clk) begin
      if (rf_ce0) regs[0] <= rf_data_in;
      if (rf_ce1) regs[1] <= rf_data_in;
      if (rf_ce2) regs[2] <= rf_data_in;
      if (rf_ce3) regs[3] <= sw;
   end
   assign rf_data_out = regs[rf_addr];

   typedef struct {
      int unsigned cyc;
      logic        err;
      logic [7:0]  data;
   } rsp_exp_t;

   typedef struct {
      int unsigned cyc;
      logic [3:0]  ce;
      logic        chk_din;
      logic [7:0]  din;
   } ce_exp_t;

   rsp_exp_t rsp_q [$];
   ce_exp_t  ce_q  [$];
   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor: every rsp_valid pulse must match the oldest expectation
   always @(negedge clk) begin
      rsp_exp_t e;
      if (rsp_valid === 1'b1) begin
         n_cmp++;
         if (rsp_q.size() == 0) begin
            n_bad++;
            $display("FAIL rsp_unexpected: cycle %0d data=%h err=%b, none expected", cyc, rsp_data, rsp_err);
         end else begin
            e = rsp_q.pop_front();
            if ((cyc != e.cyc) || (rsp_err !== e.err) || (rsp_data !== e.data)) begin
               n_bad++;
               $display("FAIL rsp: got cycle %0d err=%b data=%h, expected cycle %0d err=%b data=%h",
                        cyc, rsp_err, rsp_data, e.cyc, e.err, e.data);
            end
         end
      end
   end

   // Write-enable monitor: every enable pulse must match the oldest expectation
   always @(negedge clk) begin
      ce_exp_t    e;
      logic [3:0] ce_vec;
      ce_vec = {rf_ce3, rf_ce2, rf_ce1, rf_ce0};
      if ((|ce_vec) === 1'b1) begin
         n_cmp++;
         if (ce_q.size() == 0) begin
            n_bad++;
            $display("FAIL ce_unexpected: cycle %0d ce=%b din=%h, none expected", cyc, ce_vec, rf_data_in);
         end else begin
            e = ce_q.pop_front();
            if ((cyc != e.cyc) || (ce_vec !== e.ce) || (e.chk_din && (rf_data_in !== e.din))) begin
               n_bad++;
               $display("FAIL ce: got cycle %0d ce=%b din=%h, expected cycle %0d ce=%b din=%h",
                        cyc, ce_vec, rf_data_in, e.cyc, e.ce, e.din);
            end
         end
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 8 && !ok; i++) begin
         if (req_ready === 1'b1) ok = 1'b1;
         else @(negedge clk);
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL idle_timeout: req_ready=%b at cycle %0d, expected 1 within 8 cycles", req_ready, cyc);
      end
   endtask

   // Issue one request at a negedge; lat 0 for ce_lat means no enable expected
   task automatic issue(input logic [1:0] op, input logic [1:0] dst, input logic [1:0] src,
                        input logic [7:0] imm,
                        input int unsigned rsp_lat, input logic exp_err, input logic [7:0] exp_data,
                        input int unsigned ce_lat, input logic [3:0] exp_ce,
                        input logic chk_din, input logic [7:0] exp_din,
                        input logic chk_addr, input logic [1:0] exp_addr);
      int unsigned t;
      rsp_exp_t    r;
      ce_exp_t     c;
      check("ready_before_req", req_ready, 1);
      req_op    = op;
      req_dst   = dst;
      req_src   = src;
      req_imm   = imm;
      req_valid = 1'b1;
      t = cyc;
      r.cyc = t + rsp_lat;  r.err = exp_err;  r.data = exp_data;
      rsp_q.push_back(r);
      if (ce_lat != 0) begin
         c.cyc = t + ce_lat;  c.ce = exp_ce;  c.chk_din = chk_din;  c.din = exp_din;
         ce_q.push_back(c);
      end
      @(negedge clk);
      req_valid = 1'b0;
      if (chk_addr) check("rd_addr", rf_addr, exp_addr);
      wait_idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int unsigned t;
      rsp_exp_t    r;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_op    = 2'b00;
      req_dst   = 2'd0;
      req_src   = 2'd0;
      req_imm   = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_ready", req_ready, 1);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 0);
      check("rst_rf_addr", rf_addr, 0);
      check("rst_rf_data_in", rf_data_in, 0);
      check("rst_ce", {rf_ce3, rf_ce2, rf_ce1, rf_ce0}, 0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle", {req_ready, rf_ce3, rf_ce2, rf_ce1, rf_ce0, rsp_valid}, 6'b100000);
      end

      // WRITE_IMM r1 = A5; rf_addr must not move
      issue(2'b01, 2'd1, 2'd0, 8'hA5, 2, 1'b0, 8'hA5, 1, 4'b0010, 1'b1, 8'hA5, 1'b0, 2'd0);
      check("addr_hold_wr", rf_addr, 0);
      // READ r1
      issue(2'b00, 2'd0, 2'd1, 8'h00, 2, 1'b0, 8'hA5, 0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd1);
      // MOVE r1 -> r2
      issue(2'b10, 2'd2, 2'd1, 8'h00, 3, 1'b0, 8'hA5, 2, 4'b0100, 1'b1, 8'hA5, 1'b1, 2'd1);
      // READ r2
      issue(2'b00, 2'd0, 2'd2, 8'h00, 2, 1'b0, 8'hA5, 0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd2);
      // LOAD_SW (dst ignored)
      issue(2'b11, 2'd1, 2'd0, 8'h00, 2, 1'b0, 8'h00, 1, 4'b1000, 1'b0, 8'h00, 1'b0, 2'd0);
      // READ r3 returns the switches
      issue(2'b00, 2'd0, 2'd3, 8'h00, 2, 1'b0, 8'h3C, 0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd3);
      // Illegal WRITE_IMM r3
      issue(2'b01, 2'd3, 2'd0, 8'h77, 1, 1'b1, 8'h00, 0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      // Illegal MOVE r0 -> r3: no RD, rf_addr keeps 3
      issue(2'b10, 2'd3, 2'd0, 8'h00, 1, 1'b1, 8'h00, 0, 4'b0000, 1'b0, 8'h00, 1'b0, 2'd0);
      check("addr_hold_illegal", rf_addr, 3);
      // MOVE r2 -> r2
      issue(2'b10, 2'd2, 2'd2, 8'h00, 3, 1'b0, 8'hA5, 2, 4'b0100, 1'b1, 8'hA5, 1'b1, 2'd2);

      // Reset during MOVE r1 -> r0 RD cycle aborts the operation
      req_op    = 2'b10;
      req_dst   = 2'd0;
      req_src   = 2'd1;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b1;
      @(negedge clk);
      check("abort_state", {req_ready, rf_ce3, rf_ce2, rf_ce1, rf_ce0, rsp_valid}, 6'b100000);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      // r0 untouched by the aborted MOVE
      issue(2'b00, 2'd0, 2'd0, 8'h00, 2, 1'b0, 8'h00, 0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);
      // WRITE_IMM r0 = 5A, then READ r0
      issue(2'b01, 2'd0, 2'd0, 8'h5A, 2, 1'b0, 8'h5A, 1, 4'b0001, 1'b1, 8'h5A, 1'b0, 2'd0);
      issue(2'b00, 2'd0, 2'd0, 8'h00, 2, 1'b0, 8'h5A, 0, 4'b0000, 1'b0, 8'h00, 1'b1, 2'd0);

      // READ r3 with req_valid held: accepted at T and T+3 only
      req_op    = 2'b00;
      req_src   = 2'd3;
      req_valid = 1'b1;
      t = cyc;
      r.cyc = t + 2;  r.err = 1'b0;  r.data = 8'h3C;
      rsp_q.push_back(r);
      r.cyc = t + 5;
      rsp_q.push_back(r);
      repeat (4) @(negedge clk);
      req_valid = 1'b0;
      wait_idle();

      // MOVE r3 -> r0 carries the switch value
      issue(2'b10, 2'd0, 2'd3, 8'h00, 3, 1'b0, 8'h3C, 2, 4'b0001, 1'b1, 8'h3C, 1'b1, 2'd3);

      repeat (3) @(negedge clk);
      check("rsp_queue_drained", rsp_q.size(), 0);
      check("ce_queue_drained", ce_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
